jtkcpu_stack_regs: RTL and testbench

Programmer-visible register file (A, B, DP, X, Y, U, S) of the Konami CPU core, combined with the PSHS/PSHU/PULS/PULU byte sequencer. The ALU writes registers through `up_*` strobes. The sequencer walks a latched postbyte and emits one memory byte access per clock. It updates the active stack pointer and pulled registers itself, and hands CC/PC pulls back to the core.

---
 rtl/jtkcpu_stack_regs.sv | 228 ++++++++++++++++++++++
 tb/tb_jtkcpu_stack_regs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_stack_regs.sv
// jtkcpu_stack_regs
// Register file for the Konami CPU core (A, B, DP, X, Y, U, S), combined with
// the PSHS/PSHU/PULS/PULU byte sequencer. The sequencer walks a latched
// postbyte mask and emits one memory byte access per clock. Pushes run from
// b7 down to b0, and pulls run from b0 up to b7. The sequencer updates the
// active stack pointer and any pulled register itself. CC and PC pulls are
// handed back to the core.

module jtkcpu_stack_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu,
  input  logic        up_a,
  input  logic        up_b,
  input  logic        up_dp,
  input  logic        up_x,
  input  logic        up_y,
  input  logic        up_u,
  input  logic        up_s,
  input  logic [7:0]  cc,
  input  logic [15:0] pc,
  input  logic [7:0]  din,
  input  logic [7:0]  postbyte,
  input  logic        us_sel,
  input  logic        psh_go,
  input  logic        pul_go,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  dp,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] u,
  output logic [15:0] s,
  output logic [15:0] psh_addr,
  output logic [7:0]  psh_mux,
  output logic        wr,
  output logic        rd,
  output logic        up_pul_cc,
  output logic        up_pul_pc,
  output logic [15:0] pul_pc,
  output logic        idle
);

  typedef enum logic {
    DIR_PUSH = 1'b0,
    DIR_PULL = 1'b1
  } dir_t;

  logic [7:0]  mask;
  logic        hilo;
  dir_t        dir;
  logic        sel;
  logic [7:0]  pc_hi;

  logic        busy;
  logic [2:0]  cur_idx;
  logic        is_wide;
  logic        pulling;
  logic [15:0] sp_cur;
  logic [15:0] sp_other;
  logic [15:0] sp_step;
  logic [15:0] push_word;
  logic [7:0]  push_byte;

  logic [7:0]  a_nx, b_nx, dp_nx;
  logic [15:0] x_nx, y_nx, u_nx, s_nx;

  // Replace one byte of a 16-bit word. The high byte is chosen when hi is set.
  function automatic logic [15:0] put_byte(input logic [15:0] w,
                                           input logic        hi,
                                           input logic [7:0]  d);
    put_byte = hi ? {d, w[7:0]} : {w[15:8], d};
  endfunction

  assign busy     = |mask;
  assign idle     = ~busy;
  assign is_wide  = cur_idx[2];
  assign pulling  = busy && (dir == DIR_PULL);
  assign sp_cur   = sel ? s : u;
  assign sp_other = sel ? u : s;
  assign sp_step  = (dir == DIR_PUSH) ? sp_cur - 16'd1 : sp_cur + 16'd1;

  // Pick the entry to serve: the highest set bit for a push, the lowest for a pull.
  always_comb begin
    cur_idx = 3'd0;
    if (dir == DIR_PUSH) begin
      for (int i = 0; i < 8; i++)
        if (mask[i]) cur_idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (mask[i]) cur_idx = 3'(i);
    end
  end

  // Select the source word for the current push entry, then the byte within it.
  // A push sends the low byte first, so the high byte goes out once hilo is set.
  always_comb begin
    push_word = 16'h0000;
    case (cur_idx)
      3'd0: push_word = {8'h00, cc};
      3'd1: push_word = {8'h00, a};
      3'd2: push_word = {8'h00, b};
      3'd3: push_word = {8'h00, dp};
      3'd4: push_word = x;
      3'd5: push_word = y;
      3'd6: push_word = sp_other;
      3'd7: push_word = pc;
      default: push_word = 16'h0000;
    endcase
    push_byte = hilo ? push_word[15:8] : push_word[7:0];
  end

  // Drive the memory strobes and the CC/PC handoff from the sequencer state.
  always_comb begin
    wr        = 1'b0;
    rd        = 1'b0;
    psh_addr  = 16'h0000;
    psh_mux   = 8'h00;
    up_pul_cc = 1'b0;
    up_pul_pc = 1'b0;
    pul_pc    = 16'h0000;
    if (busy) begin
      if (dir == DIR_PUSH) begin
        wr       = 1'b1;
        psh_addr = sp_cur - 16'd1;
        psh_mux  = push_byte;
      end else begin
        rd       = 1'b1;
        psh_addr = sp_cur;
        if (cur_idx == 3'd0) up_pul_cc = 1'b1;
        if (cur_idx == 3'd7 && hilo) begin
          up_pul_pc = 1'b1;
          pul_pc    = {pc_hi, din};
        end
      end
    end
  end

  // Compute each register's next value. ALU strobes are applied first, so any
  // sequencer write that follows overrides them for the same register.
  always_comb begin
    a_nx  = a;
    b_nx  = b;
    dp_nx = dp;
    x_nx  = x;
    y_nx  = y;
    u_nx  = u;
    s_nx  = s;
    if (up_a)  a_nx  = alu[7:0];
    if (up_b)  b_nx  = alu[7:0];
    if (up_dp) dp_nx = alu[7:0];
    if (up_x)  x_nx  = alu;
    if (up_y)  y_nx  = alu;
    if (up_u)  u_nx  = alu;
    if (up_s)  s_nx  = alu;
    if (pulling) begin
      case (cur_idx)
        3'd1: a_nx  = din;
        3'd2: b_nx  = din;
        3'd3: dp_nx = din;
        3'd4: x_nx  = put_byte(x, ~hilo, din);
        3'd5: y_nx  = put_byte(y, ~hilo, din);
        3'd6: begin
          if (sel) u_nx = put_byte(u, ~hilo, din);
          else     s_nx = put_byte(s, ~hilo, din);
        end
        default: ;
      endcase
    end
    if (busy) begin
      if (sel) s_nx = sp_step;
      else     u_nx = sp_step;
    end
  end

  // Hold the programmer-visible registers. Reset clears all of them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a  <= 8'h00;
      b  <= 8'h00;
      dp <= 8'h00;
      x  <= 16'h0000;
      y  <= 16'h0000;
      u  <= 16'h0000;
      s  <= 16'h0000;
    end else begin
      a  <= a_nx;
      b  <= b_nx;
      dp <= dp_nx;
      x  <= x_nx;
      y  <= y_nx;
      u  <= u_nx;
      s  <= s_nx;
    end
  end

  // Sequencer: latch a new mask while idle, otherwise retire one byte per clock.
  // A 16-bit entry takes two clocks and clears its bit only after the second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask  <= 8'h00;
      hilo  <= 1'b0;
      dir   <= DIR_PUSH;
      sel   <= 1'b0;
      pc_hi <= 8'h00;
    end else if (!busy) begin
      hilo <= 1'b0;
      if (psh_go) begin
        mask <= postbyte;
        dir  <= DIR_PUSH;
        sel  <= us_sel;
      end else if (pul_go) begin
        mask <= postbyte;
        dir  <= DIR_PULL;
        sel  <= us_sel;
      end
    end else begin
      if (is_wide && !hilo) begin
        hilo <= 1'b1;
      end else begin
        hilo          <= 1'b0;
        mask[cur_idx] <= 1'b0;
      end
      if (pulling && cur_idx == 3'd7 && !hilo) pc_hi <= din;
    end
  end

endmodule

// File: tb/tb_jtkcpu_stack_regs.sv
// tb_jtkcpu_stack_regs
// Directed bench for the register file and push/pull sequencer. Each expected
// value is worked out by hand from the stack behaviour.

module tb_jtkcpu_stack_regs;

  logic        clk;
  logic        rst;
  logic [15:0] alu;
  logic        up_a, up_b, up_dp, up_x, up_y, up_u, up_s;
  logic [7:0]  cc;
  logic [15:0] pc;
  logic [7:0]  din;
  logic [7:0]  postbyte;
  logic        us_sel;
  logic        psh_go;
  logic        pul_go;
  logic [7:0]  a, b, dp;
  logic [15:0] x, y, u, s;
  logic [15:0] psh_addr;
  logic [7:0]  psh_mux;
  logic        wr, rd, up_pul_cc, up_pul_pc, idle;
  logic [15:0] pul_pc;

  int check_count;
  int error_count;

  jtkcpu_stack_regs dut (
    .clk       (clk),
    .rst       (rst),
    .alu       (alu),
    .up_a      (up_a),
    .up_b      (up_b),
    .up_dp     (up_dp),
    .up_x      (up_x),
    .up_y      (up_y),
    .up_u      (up_u),
    .up_s      (up_s),
    .cc        (cc),
    .pc        (pc),
    .din       (din),
    .postbyte  (postbyte),
    .us_sel    (us_sel),
    .psh_go    (psh_go),
    .pul_go    (pul_go),
    .a         (a),
    .b         (b),
    .dp        (dp),
    .x         (x),
    .y         (y),
    .u         (u),
    .s         (s),
    .psh_addr  (psh_addr),
    .psh_mux   (psh_mux),
    .wr        (wr),
    .rd        (rd),
    .up_pul_cc (up_pul_cc),
    .up_pul_pc (up_pul_pc),
    .pul_pc    (pul_pc),
    .idle      (idle)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Load a register from the ALU using the one-cycle strobe on that register.
  task automatic loadReg(input int which, input logic [15:0] value);
    alu = value;
    case (which)
      0: up_a = 1'b1;
      4: up_x = 1'b1;
      6: up_u = 1'b1;
      7: up_s = 1'b1;
      default: ;
    endcase
    applyStimulus();
    up_a = 1'b0; up_x = 1'b0; up_u = 1'b0; up_s = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    check_count = 0;
    error_count = 0;
    rst = 1'b1;
    alu = 16'h0000;
    {up_a, up_b, up_dp, up_x, up_y, up_u, up_s} = 7'b0;
    cc = 8'h00; pc = 16'h0000; din = 8'h00; postbyte = 8'h00;
    us_sel = 1'b0; psh_go = 1'b0; pul_go = 1'b0;

    // Reset and its idle state.
    #2 rst = 1'b0;
    #20 rst = 1'b1;
    applyStimulus();
    checkOutput("rst_a", {8'h00, a}, 16'h0000);
    checkOutput("rst_x", x, 16'h0000);
    checkOutput("rst_u", u, 16'h0000);
    checkOutput("rst_s", s, 16'h0000);
    checkOutput("rst_idle", {15'd0, idle}, 16'h0001);
    checkOutput("rst_wr_rd", {14'd0, wr, rd}, 16'h0000);

    // A zero postbyte must leave the block idle.
    psh_go = 1'b1; postbyte = 8'h00;
    applyStimulus();
    psh_go = 1'b0;
    checkOutput("zero_pb_idle", {15'd0, idle}, 16'h0001);
    checkOutput("zero_pb_wr", {15'd0, wr}, 16'h0000);

    // Push X onto U.
    loadReg(6, 16'h1000);
    loadReg(4, 16'h1234);
    checkOutput("load_u", u, 16'h1000);
    checkOutput("load_x", x, 16'h1234);
    postbyte = 8'h10; us_sel = 1'b0; psh_go = 1'b1;
    applyStimulus();
    psh_go = 1'b0;
    checkOutput("pshx_c1_idle", {15'd0, idle}, 16'h0000);
    checkOutput("pshx_c1_wr", {15'd0, wr}, 16'h0001);
    checkOutput("pshx_c1_addr", psh_addr, 16'h0FFF);
    checkOutput("pshx_c1_data", {8'h00, psh_mux}, 16'h0034);
    applyStimulus();
    checkOutput("pshx_c2_addr", psh_addr, 16'h0FFE);
    checkOutput("pshx_c2_data", {8'h00, psh_mux}, 16'h0012);
    checkOutput("pshx_c2_u", u, 16'h0FFF);
    applyStimulus();
    checkOutput("pshx_done_idle", {15'd0, idle}, 16'h0001);
    checkOutput("pshx_done_wr", {15'd0, wr}, 16'h0000);
    checkOutput("pshx_done_u", u, 16'h0FFE);

    // Pull X back from U, starting from a cleared X.
    loadReg(4, 16'h0000);
    postbyte = 8'h10; us_sel = 1'b0; pul_go = 1'b1;
    applyStimulus();
    pul_go = 1'b0;
    din = 8'h12; #1;
    checkOutput("pulx_c1_rd", {15'd0, rd}, 16'h0001);
    checkOutput("pulx_c1_wr", {15'd0, wr}, 16'h0000);
    checkOutput("pulx_c1_addr", psh_addr, 16'h0FFE);
    applyStimulus();
    din = 8'h34; #1;
    checkOutput("pulx_c2_addr", psh_addr, 16'h0FFF);
    checkOutput("pulx_c2_x", x, 16'h1200);
    applyStimulus();
    checkOutput("pulx_done_x", x, 16'h1234);
    checkOutput("pulx_done_u", u, 16'h1000);
    checkOutput("pulx_done_idle", {15'd0, idle}, 16'h0001);

    // Push PC and CC onto S.
    loadReg(7, 16'h2000);
    pc = 16'hABCD; cc = 8'h55;
    postbyte = 8'h81; us_sel = 1'b1; psh_go = 1'b1;
    applyStimulus();
    psh_go = 1'b0;
    checkOutput("pshpc_c1_addr", psh_addr, 16'h1FFF);
    checkOutput("pshpc_c1_data", {8'h00, psh_mux}, 16'h00CD);
    applyStimulus();
    checkOutput("pshpc_c2_addr", psh_addr, 16'h1FFE);
    checkOutput("pshpc_c2_data", {8'h00, psh_mux}, 16'h00AB);
    applyStimulus();
    checkOutput("pshcc_c3_addr", psh_addr, 16'h1FFD);
    checkOutput("pshcc_c3_data", {8'h00, psh_mux}, 16'h0055);
    applyStimulus();
    checkOutput("pshpc_done_s", s, 16'h1FFD);
    checkOutput("pshpc_done_u", u, 16'h1000);
    checkOutput("pshpc_done_idle", {15'd0, idle}, 16'h0001);

    // Pull CC and PC back from S.
    postbyte = 8'h81; us_sel = 1'b1; pul_go = 1'b1;
    applyStimulus();
    pul_go = 1'b0;
    din = 8'h55; #1;
    checkOutput("pulcc_c1_addr", psh_addr, 16'h1FFD);
    checkOutput("pulcc_c1_flags", {14'd0, up_pul_cc, up_pul_pc}, 16'h0002);
    applyStimulus();
    din = 8'hAB; #1;
    checkOutput("pulpc_c2_addr", psh_addr, 16'h1FFE);
    checkOutput("pulpc_c2_flags", {14'd0, up_pul_cc, up_pul_pc}, 16'h0000);
    applyStimulus();
    din = 8'hCD; #1;
    checkOutput("pulpc_c3_addr", psh_addr, 16'h1FFF);
    checkOutput("pulpc_c3_flags", {14'd0, up_pul_cc, up_pul_pc}, 16'h0001);
    checkOutput("pulpc_c3_value", pul_pc, 16'hABCD);
    applyStimulus();
    checkOutput("pulpc_done_s", s, 16'h2000);
    checkOutput("pulpc_done_idle", {15'd0, idle}, 16'h0001);

    // The sequencer's SP write beats up_u, while up_a to another register still lands.
    postbyte = 8'h02; us_sel = 1'b0; psh_go = 1'b1;
    applyStimulus();
    psh_go = 1'b0;
    alu = 16'h5555; up_u = 1'b1; up_a = 1'b1; #1;
    checkOutput("conf_c1_addr", psh_addr, 16'h0FFF);
    checkOutput("conf_c1_data", {8'h00, psh_mux}, 16'h0000);
    applyStimulus();
    up_u = 1'b0; up_a = 1'b0;
    checkOutput("conf_u_wins", u, 16'h0FFF);
    checkOutput("conf_a_loaded", {8'h00, a}, 16'h0055);
    checkOutput("conf_idle", {15'd0, idle}, 16'h0001);

    // In a full 0xFF push to U, byte 4 is the high byte of S. Reset then aborts it.
    postbyte = 8'hFF; us_sel = 1'b0; psh_go = 1'b1;
    applyStimulus();
    psh_go = 1'b0;
    checkOutput("ff_c1_addr", psh_addr, 16'h0FFE);
    checkOutput("ff_c1_data", {8'h00, psh_mux}, 16'h00CD);
    applyStimulus();
    applyStimulus();
    checkOutput("ff_c3_data", {8'h00, psh_mux}, 16'h0000);
    applyStimulus();
    checkOutput("ff_c4_addr", psh_addr, 16'h0FFB);
    checkOutput("ff_c4_data", {8'h00, psh_mux}, 16'h0020);
    rst = 1'b0; #1;
    checkOutput("abort_idle", {15'd0, idle}, 16'h0001);
    checkOutput("abort_wr", {15'd0, wr}, 16'h0000);
    checkOutput("abort_u", u, 16'h0000);
    checkOutput("abort_s", s, 16'h0000);
    checkOutput("abort_a", {8'h00, a}, 16'h0000);
    #3 rst = 1'b1;
    applyStimulus();
    checkOutput("post_abort_idle", {15'd0, idle}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
